// File: rtl/g9_imem_loader.sv
// g9_imem_loader: boot-time byte-stream loader for the G9 instruction memory.
// Frame: LEN_HI, LEN_LO (word count N), then N big-endian 32-bit words.
// Optional feature macro G9_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// over the data bytes; a mismatch halts in the error state.
// The processor is held in reset until the image completes successfully.

module g9_imem_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_din,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StLenH,
    StLenL,
    StData,
`ifdef G9_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

  state_e              state_q;
  logic [15:0]         len_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [1:0]          bcnt_q;
  logic [23:0]         asm_q;
`ifdef G9_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic        accept;
  logic [15:0] len_new;
  logic        last_word;

  assign accept    = rx_valid & rx_ready;
  assign len_new   = {len_q[15:8], rx_data};
  // len_q is at least 1 whenever the data state is reachable
  assign last_word = (16'(widx_q) == (len_q - 16'd1));

  // Byte acceptance is a pure decode of the current state
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      StLenH, StLenL, StData: rx_ready = 1'b1;
`ifdef G9_LOADER_CHECKSUM_EN
      StCsum:                 rx_ready = 1'b1;
`endif
      default:                rx_ready = 1'b0;
    endcase
  end

  // Loader FSM with registered memory-write and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      widx_q    <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
`ifdef G9_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_din  <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      // Release lags entry to DONE by one cycle so the last write strobe finishes
      // first; a reload re-asserts the hold immediately.
      cpu_reset <= (state_q != StDone) | reload;
      case (state_q)
        StIdle: state_q <= StLenH;
        StLenH: begin
          if (accept) begin
            len_q[15:8] <= rx_data;
            state_q     <= StLenL;
          end
        end
        StLenL: begin
          if (accept) begin
            len_q[7:0] <= rx_data;
            if (len_new == 16'd0 || 32'(len_new) > Depth) begin
              state_q <= StErr;
              error   <= 1'b1;
            end else begin
              state_q <= StData;
              widx_q  <= '0;
              bcnt_q  <= '0;
`ifdef G9_LOADER_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
        end
        StData: begin
          if (accept) begin
`ifdef G9_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            if (bcnt_q == 2'd3) begin
              imem_we   <= 1'b1;
              imem_addr <= widx_q;
              imem_din  <= DATA_W'({asm_q, rx_data});
              widx_q    <= widx_q + 1'b1;
              bcnt_q    <= '0;
              if (last_word) begin
`ifdef G9_LOADER_CHECKSUM_EN
                state_q <= StCsum;
`else
                state_q <= StDone;
                done    <= 1'b1;
`endif
              end
            end else begin
              asm_q  <= {asm_q[15:0], rx_data};
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
        end
`ifdef G9_LOADER_CHECKSUM_EN
        StCsum: begin
          if (accept) begin
            if (rx_data == csum_q) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StErr;
              error   <= 1'b1;
            end
          end
        end
`endif
        StDone, StErr: begin
          if (reload) begin
            state_q <= StLenH;
            done    <= 1'b0;
            error   <= 1'b0;
            len_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
`ifdef G9_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_g9_imem_loader.sv
// Self-checking bench for g9_imem_loader: a frame-level byte-count model is
// compared against the DUT on every falling edge, plus literal scenario checks.
// Honours G9_LOADER_CHECKSUM_EN in the same way as the design.

module tb_g9_imem_loader;

  localparam int unsigned AddrW = 9;
`ifdef G9_LOADER_CHECKSUM_EN
  localparam bit Csum = 1'b1;
`else
  localparam bit Csum = 1'b0;
`endif
  localparam int MIdle = 0, MLoad = 1, MDone = 2, MErr = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             reload = 1'b0;
  logic             imem_we;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_din;
  logic             cpu_reset;
  logic             done;
  logic             error;

  g9_imem_loader #(.ADDR_W(AddrW), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wcount = 0;
  logic [31:0] cap_mem [512];
  logic [7:0]  tx_q [$];
  logic [31:0] img [$];

  // Frame-level model state
  int          m_mode = MIdle;
  int          m_cnt = 0;
  int unsigned m_len = 0;
  logic [31:0] m_word = '0;
  logic [7:0]  m_x = '0;
  logic        m_we = 1'b0;
  logic [8:0]  m_addr = '0;
  logic [31:0] m_din = '0;
  logic        m_cpu = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare then advance the model across the coming rising edge
  always @(negedge clk) begin : compare
    int d;
    bit nxt_we, nxt_cpu;
    if (!reset) begin
      m_mode = MIdle; m_we = 1'b0; m_addr = '0; m_din = '0; m_cpu = 1'b1;
      m_cnt = 0; m_x = '0;
    end
    chk("rx_ready", 32'(rx_ready), 32'(m_mode == MLoad));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("imem_din", imem_din, m_din);
    chk("done", 32'(done), 32'(m_mode == MDone));
    chk("error", 32'(error), 32'(m_mode == MErr));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu));
    if (imem_we) begin
      cap_mem[imem_addr] = imem_din;
      wcount++;
    end
    if (reset) begin
      nxt_we = 1'b0;
      nxt_cpu = (m_mode != MDone);
      case (m_mode)
        MIdle: begin m_mode = MLoad; m_cnt = 0; end
        MLoad: if (rx_valid) begin
          if (m_cnt == 0) begin
            m_len = 32'(rx_data) << 8;
          end else if (m_cnt == 1) begin
            m_len = m_len + 32'(rx_data);
            m_x = '0;
            if (m_len == 0 || m_len > (1 << AddrW)) m_mode = MErr;
          end else if (m_cnt < 2 + 4 * int'(m_len)) begin
            d = m_cnt - 2;
            m_word = {m_word[23:0], rx_data};
            m_x = m_x ^ rx_data;
            if (d % 4 == 3) begin
              nxt_we = 1'b1;
              m_addr = 9'(d / 4);
              m_din = m_word;
            end
            if (d == 4 * int'(m_len) - 1 && !Csum) m_mode = MDone;
          end else begin
            m_mode = (rx_data == m_x) ? MDone : MErr;
          end
          m_cnt++;
        end
        default: if (reload) begin
          m_mode = MLoad; m_cnt = 0; nxt_cpu = 1'b1;
        end
      endcase
      m_we = nxt_we;
      m_cpu = nxt_cpu;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push a full frame for the words in img (plus checksum byte when enabled)
  task automatic build_frame();
    logic [7:0] x = '0;
    logic [31:0] w;
    int n = img.size();
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    foreach (img[i]) begin
      w = img[i];
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    if (Csum) tx_q.push_back(x);
  endtask

  // Drive tx_q with random idle gaps; returns in the cycle after the last transfer
  task automatic send(input int gap_pct);
    int budget = 4000;
    bit xfer;
    while (tx_q.size() > 0) begin
      rx_data = tx_q[0];
      rx_valid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      xfer = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (xfer) void'(tx_q.pop_front());
      budget--;
      if (budget == 0) begin
        chk("send_timeout", 32'(tx_q.size()), 32'd0);
        tx_q.delete();
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic check_image(input string name);
    chk({name, "_wcount"}, 32'(wcount), 32'(img.size()));
    foreach (img[i]) chk({name, "_word"}, cap_mem[i], img[i]);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) cap_mem[i] = 32'hDEADBEEF;
    repeat (2) tick();
    reset = 1'b1;

    // Literal reference image with exact completion timing
    wcount = 0;
    img = '{32'h20210005, 32'h8C00FFFF};
    build_frame();
    send(0);
    @(negedge clk);
    chk("t1_done_k1", 32'(done), 32'd1);
    chk("t1_we_k1", 32'(imem_we), 32'(!Csum));
    chk("t1_cpu_k1", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("t1_cpu_k2", 32'(cpu_reset), 32'd0);
    tick();
    chk("t1_wcount", 32'(wcount), 32'd2);
    chk("t1_addr0", cap_mem[0], 32'h20210005);
    chk("t1_addr1", cap_mem[1], 32'h8C00FFFF);

    // Zero length and oversize length both halt without writes
    for (int k = 0; k < 2; k++) begin
      pulse_reload();
      wcount = 0;
      tx_q.delete();
      tx_q.push_back(k == 0 ? 8'h00 : 8'h02);
      tx_q.push_back(k == 0 ? 8'h00 : 8'h01);
      send(0);
      repeat (2) tick();
      chk("t2_error", 32'(error), 32'd1);
      chk("t2_rx_ready", 32'(rx_ready), 32'd0);
      chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t2_wcount", 32'(wcount), 32'd0);
    end

    // Gappy stream, N=3
    pulse_reload();
    wcount = 0;
    img = '{$urandom(), $urandom(), $urandom()};
    build_frame();
    send(50);
    repeat (3) tick();
    check_image("t3");

    // Reset after 6 data bytes of an N=4 image, then a clean reload
    pulse_reload();
    img = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    build_frame();
    while (tx_q.size() > 8) void'(tx_q.pop_back());
    send(0);
    reset = 1'b0;
    #1;
    chk("t4_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("t4_rst_we", 32'(imem_we), 32'd0);
    chk("t4_rst_addr", 32'(imem_addr), 32'd0);
    chk("t4_rst_din", imem_din, 32'd0);
    chk("t4_rst_cpu", 32'(cpu_reset), 32'd1);
    chk("t4_rst_done", 32'(done), 32'd0);
    chk("t4_rst_error", 32'(error), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cap_mem[i] = 32'hDEADBEEF;
    wcount = 0;
    build_frame();
    send(20);
    repeat (3) tick();
    check_image("t4");

    // Reload from DONE re-asserts cpu_reset at once; N=1 overwrites addr 0
    pulse_reload();
    @(negedge clk);
    chk("t5_cpu_after_reload", 32'(cpu_reset), 32'd1);
    chk("t5_done_cleared", 32'(done), 32'd0);
    tick();
    wcount = 0;
    img = '{32'hCAFEF00D};
    build_frame();
    send(0);
    repeat (3) tick();
    check_image("t5");
    chk("t5_done", 32'(done), 32'd1);

    // Random images with random gaps
    for (int f = 0; f < 6; f++) begin
      pulse_reload();
      wcount = 0;
      img.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) img.push_back($urandom());
      build_frame();
      send(30);
      repeat (3) tick();
      check_image("t6");
      chk("t6_cpu_released", 32'(cpu_reset), 32'd0);
    end

`ifdef G9_LOADER_CHECKSUM_EN
    // 01^02^03^04 = 04: match then mismatch
    for (int k = 0; k < 2; k++) begin
      pulse_reload();
      cap_mem[0] = 32'hDEADBEEF;
      tx_q.delete();
      tx_q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
      tx_q.push_back(k == 0 ? 8'h04 : 8'h05);
      send(0);
      repeat (3) tick();
      chk("t7_word", cap_mem[0], 32'h01020304);
      chk("t7_done", 32'(done), 32'(k == 0));
      chk("t7_error", 32'(error), 32'(k == 1));
      chk("t7_cpu", 32'(cpu_reset), 32'(k == 1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/g9_imem_loader.md
# g9_imem_loader

Boot-time program loader for the G9 KGP-RISC core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at word address 0. It holds the processor in reset until the image is complete. It is the write side of the instruction memory, whose read side is the processor fetch path.

## Interface
Parameters:
- ADDR_W, 9: instruction memory word-address width; capacity is 2^ADDR_W words (512).
- DATA_W, 32: instruction word width. Must be 32; four bytes per word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte source has a byte on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can accept a byte. A byte transfers on an edge where rx_valid & rx_ready.
- reload  in  1  single-cycle request to restart loading from DONE or ERR; ignored in other states.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_din  out  DATA_W  word to write.
- cpu_reset  out  1  active-high hold to the processor reset input.
- done  out  1  image loaded successfully.
- error  out  1  malformed image; the loader is halted.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 data bytes, MSB first per word.
  - Optional checksum byte (see Configuration).
- States: IDLE, LENH, LENL, DATA, CSUM, DONE, ERR.
- IDLE: rx_ready=0. Goes to LENH unconditionally on the next edge.
- LENH / LENL: rx_ready=1. Each accepted byte fills the upper/lower byte of the count register.
- Leaving LENL:
  - N==0 or N>2^ADDR_W → ERR.
  - Otherwise → DATA, with the word index cleared to 0.
- DATA: rx_ready=1. A 2-bit byte counter shifts bytes into the assembly register.
- On the 4th byte of a word:
  - The assembled word and the word index are registered onto imem_din/imem_addr, with imem_we=1 for the following cycle.
  - The word index increments.
  - The byte counter wraps to 0.
- The last byte of word N-1 moves to CSUM (macro defined) or DONE.
- DONE: rx_ready=0, done=1.
- ERR: rx_ready=0, error=1. cpu_reset stays 1 in ERR.
- reload in DONE/ERR: → LENH. Clears done, error, counters and checksum. cpu_reset re-asserts on the next edge.
- cpu_reset is a register equal to (state != DONE), delayed one cycle.
- Bytes presented while rx_ready=0 are not consumed.
- rx_valid may drop mid-word. The partial word is held indefinitely; there is no timeout.
- imem_addr/imem_din hold their last values when imem_we=0.

## Timing
- Reset values:
  - state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_din=0, cpu_reset=1, done=0, error=0.
  - All counters and the checksum are 0.
- Reset asserted mid-load: everything returns to reset values immediately. The partial word is discarded, and words already written stay in memory.
- Throughput: one byte per cycle. A word write issues every 4 cycles at most, with no stall between words.
- Write latency: the edge accepting the 4th byte of a word registers it; imem_we is high in the following cycle.
- Final byte accepted at edge k:
  - imem_we=1 and state=DONE (or CSUM) during cycle k+1.
  - done=1 from k+1.
  - cpu_reset falls at edge k+2.
- In DONE, cpu_reset is never released before the final write strobe has completed.
- Checksum byte accepted at edge k: state=DONE or ERR from k+1; cpu_reset falls at k+2 only on match.
- reload and reset together: reset wins.

## Configuration
- G9_LOADER_CHECKSUM_EN defined:
  - The CSUM state exists.
  - A running XOR of all data bytes (not the length bytes) is kept.
  - After the last data byte, one checksum byte is expected: equal → DONE, different → ERR.
- Undefined: no CSUM state and no XOR register. The last data byte goes directly to DONE.

## Test plan
- Load N=2 (00 02, 20 21 00 05, 8C 00 FF FF), rx_valid held high → imem_we pulses exactly twice: addr 0 = 0x20210005, addr 1 = 0x8C00FFFF. done=1 one cycle after the last byte; cpu_reset=0 the cycle after that.
- Length 00 00, and separately 02 01 (513) → ERR, error=1, rx_ready=0, cpu_reset=1, no imem_we pulses.
- Random rx_valid gaps inside a word, N=3 → identical written words and addresses. imem_we is never asserted for a partial word.
- Reset asserted after 6 data bytes of an N=4 image:
  - Outputs return to reset values immediately.
  - Reloading the full image from LENH writes addr 0..3 correctly.
- DONE, then a reload pulse → cpu_reset=1 the next cycle. A second image with N=1 overwrites addr 0, and done reasserts.
- With G9_LOADER_CHECKSUM_EN, N=1 data 01 02 03 04:
  - Checksum 04 → DONE.
  - Checksum 05 → ERR, with cpu_reset held at 1 even though addr 0 was written.
